// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array result reader.
package systolic_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_SIZE  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    STREAM  = 2'd3
  } rdr_state_t;

  // Cycles from operand entry until the array product settles.
  function automatic int unsigned rdr_latency(input int unsigned size);
    return 3 * size - 2;
  endfunction

endpackage

// File: rtl/systolic_idx_walker.sv
// Row/col index walker for the result stream. Order is row-major by default;
// SYSTOLIC_RDR_COLMAJOR_EN selects column-major (row index advances first).
module systolic_idx_walker #(
  parameter int unsigned SIZE = 3,
  parameter int unsigned IW   = 2
) (
  input  logic          clock,
  input  logic          nreset,
  input  logic          clear,
  input  logic          advance,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col,
  output logic          last,
  output logic [IW-1:0] next_row_c,
  output logic [IW-1:0] next_col_c
);

  localparam logic [IW-1:0] MAX_IDX = IW'(SIZE - 1);

  logic last_d;

  // Next index: restart on clear, step in the selected major order on advance.
  always_comb begin
    next_row_c = row;
    next_col_c = col;
    if (clear) begin
      next_row_c = '0;
      next_col_c = '0;
    end else if (advance) begin
`ifdef SYSTOLIC_RDR_COLMAJOR_EN
      if (row == MAX_IDX) begin
        next_row_c = '0;
        next_col_c = (col == MAX_IDX) ? '0 : col + IW'(1);
      end else begin
        next_row_c = row + IW'(1);
      end
`else
      if (col == MAX_IDX) begin
        next_col_c = '0;
        next_row_c = (row == MAX_IDX) ? '0 : row + IW'(1);
      end else begin
        next_col_c = col + IW'(1);
      end
`endif
    end
    last_d = (next_row_c == MAX_IDX) && (next_col_c == MAX_IDX);
  end

  // Index and last-flag registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      row  <= '0;
      col  <= '0;
      last <= 1'b0;
    end else begin
      row  <= next_row_c;
      col  <= next_col_c;
      last <= last_d;
    end
  end

endmodule

// File: rtl/systolic_result_reader.sv
// Waits for the systolic array product to settle, snapshots it, then streams
// the elements out over a valid/ready port. Optional: SYSTOLIC_RDR_COLMAJOR_EN.
module systolic_result_reader
  import systolic_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SIZE    = DEF_SIZE,
  parameter int unsigned LATENCY = rdr_latency(SIZE)
) (
  input  logic                                    clock,
  input  logic                                    nreset,
  input  logic                                    start,
  input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]    product_in,
  output logic                                    busy,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [WIDTH-1:0]                        out_data,
  output logic [((SIZE > 1) ? $clog2(SIZE) : 1)-1:0] out_row,
  output logic [((SIZE > 1) ? $clog2(SIZE) : 1)-1:0] out_col,
  output logic                                    out_last,
  output logic                                    done
);

  localparam int unsigned IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  rdr_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] buf_q;
  logic [WIDTH-1:0] data_d;
  logic busy_d, valid_d, done_d;
  logic hs_c, clear_c, advance_c;
  logic [IW-1:0] next_row_c, next_col_c;

  assign hs_c      = out_valid && out_ready;
  assign clear_c   = (state_q == CAPTURE);
  assign advance_c = (state_q == STREAM) && hs_c;

  systolic_idx_walker #(.SIZE(SIZE), .IW(IW)) u_walker (
    .clock      (clock),
    .nreset     (nreset),
    .clear      (clear_c),
    .advance    (advance_c),
    .row        (out_row),
    .col        (out_col),
    .last       (out_last),
    .next_row_c (next_row_c),
    .next_col_c (next_col_c)
  );

  // Next state, wait counter and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = out_data;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LATENCY - 1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = STREAM;
        data_d  = product_in[0][0];
      end
      STREAM: begin
        if (hs_c) begin
          data_d = buf_q[next_row_c][next_col_c];
          if (out_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == STREAM);
  end

  // State, counter, output and snapshot registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      buf_q     <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_data  <= data_d;
      busy      <= busy_d;
      out_valid <= valid_d;
      done      <= done_d;
      if (state_q == CAPTURE) buf_q <= product_in;
    end
  end

endmodule
